// File: rtl/rvc_asap_5pl_fpga_in.sv
// Board input front-end: synchronizes, polarity-corrects and debounces buttons and switches,
// and keeps sticky press flags plus a switch-change pulse. Macro RVC_FPGA_IN_DEBOUNCE_EN enables the counters.
module rvc_asap_5pl_fpga_in #(
    parameter int unsigned DEBOUNCE_CYCLES   = 500000,
    parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
    input  logic       Clock,
    input  logic       Rst,
    input  logic       Button_0_Raw,
    input  logic       Button_1_Raw,
    input  logic [9:0] Switch_Raw,
    input  logic [1:0] PressClr,
    output logic       Button_0,
    output logic       Button_1,
    output logic [9:0] Switch,
    output logic       Button_0_Press,
    output logic       Button_1_Press,
    output logic       SwitchChange
);

    localparam int NCH = 12;

    // Channel order: bit0 Button_0, bit1 Button_1, bits 11:2 switches; pressed buttons read 1.
    logic [NCH-1:0] raw_s;
    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] stable_q;
    logic [NCH-1:0] stable_d;
    logic           press0_q;
    logic           press0_d;
    logic           press1_q;
    logic           press1_d;
    logic           sw_chg_q;
    logic           sw_chg_d;

    assign raw_s = {Switch_Raw, Button_1_Raw ^ BUTTON_ACTIVE_LOW, Button_0_Raw ^ BUTTON_ACTIVE_LOW};

`ifdef RVC_FPGA_IN_DEBOUNCE_EN
    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    logic [NCH-1:0] sync2_q;
    logic [19:0]    cnt_q [NCH];
    logic [19:0]    cnt_d [NCH];

    // Per-channel debounce: any disagreement must persist DEBOUNCE_CYCLES cycles to be accepted.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = 20'd0;
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = 20'd0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = 20'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 20'd1;
            end
        end
    end

    // Two-flop synchronizer and debounce counters.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= 20'd0;
            end
        end else begin
            sync1_q <= raw_s;
            sync2_q <= sync1_q;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
`else
    // Without counters the stable register doubles as the second synchronizer stage.
    always_comb begin
        stable_d = sync1_q;
    end

    // First synchronizer stage.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            sync1_q <= '0;
        end else begin
            sync1_q <= raw_s;
        end
    end
`endif

    // Flag and pulse next-state; a new press wins over a simultaneous clear.
    always_comb begin
        press0_d = (stable_d[0] & ~stable_q[0]) | (press0_q & ~PressClr[0]);
        press1_d = (stable_d[1] & ~stable_q[1]) | (press1_q & ~PressClr[1]);
        sw_chg_d = |(stable_d[NCH-1:2] ^ stable_q[NCH-1:2]);
    end

    // Stable levels, sticky flags and the switch-change pulse.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            stable_q <= '0;
            press0_q <= 1'b0;
            press1_q <= 1'b0;
            sw_chg_q <= 1'b0;
        end else begin
            stable_q <= stable_d;
            press0_q <= press0_d;
            press1_q <= press1_d;
            sw_chg_q <= sw_chg_d;
        end
    end

    assign Button_0       = stable_q[0];
    assign Button_1       = stable_q[1];
    assign Switch         = stable_q[NCH-1:2];
    assign Button_0_Press = press0_q;
    assign Button_1_Press = press1_q;
    assign SwitchChange   = sw_chg_q;

endmodule

// File: tb/tb_rvc_asap_5pl_fpga_in.sv
// Directed bench for rvc_asap_5pl_fpga_in; expected latencies follow RVC_FPGA_IN_DEBOUNCE_EN.
module tb_rvc_asap_5pl_fpga_in;

    localparam int DC = 4;
`ifdef RVC_FPGA_IN_DEBOUNCE_EN
    localparam int LAT = DC + 1;
`else
    localparam int LAT = 1;
`endif
    localparam int PRE = (LAT >= 2) ? LAT - 2 : 0;

    logic       Clock = 1'b0;
    logic       Rst = 1'b0;
    logic       Button_0_Raw = 1'b1;
    logic       Button_1_Raw = 1'b1;
    logic [9:0] Switch_Raw = 10'h000;
    logic [1:0] PressClr = 2'b00;
    logic       Button_0;
    logic       Button_1;
    logic [9:0] Switch;
    logic       Button_0_Press;
    logic       Button_1_Press;
    logic       SwitchChange;

    int checks = 0;
    int failures = 0;

    rvc_asap_5pl_fpga_in #(.DEBOUNCE_CYCLES(DC), .BUTTON_ACTIVE_LOW(1'b1)) dut (
        .Clock(Clock), .Rst(Rst), .Button_0_Raw(Button_0_Raw), .Button_1_Raw(Button_1_Raw),
        .Switch_Raw(Switch_Raw), .PressClr(PressClr), .Button_0(Button_0), .Button_1(Button_1),
        .Switch(Switch), .Button_0_Press(Button_0_Press), .Button_1_Press(Button_1_Press),
        .SwitchChange(SwitchChange)
    );

    always #5 Clock = ~Clock;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [14:0] obs;
        step(3);
        obs = {Button_0, Button_1, Switch, Button_0_Press, Button_1_Press, SwitchChange};
        checks++;
        if (obs !== 15'h0000) begin
            failures++;
            $display("FAIL reset_hold: got %h expected 0000", obs);
        end
        Rst = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step(1);
            obs = {Button_0, Button_1, Switch, Button_0_Press, Button_1_Press, SwitchChange};
            checks++;
            if (obs !== 15'h0000) begin
                failures++;
                $display("FAIL reset_release cycle %0d: got %h expected 0000", c, obs);
            end
        end
    endtask

    task automatic test_press_latency();
        Button_0_Raw = 1'b0;
        step(LAT);
        checks++;
        if ({Button_0, Button_0_Press} !== 2'b00) begin
            failures++;
            $display("FAIL press_early: got %b expected 00", {Button_0, Button_0_Press});
        end
        step(1);
        checks++;
        if ({Button_0, Button_0_Press} !== 2'b11) begin
            failures++;
            $display("FAIL press_rise: got %b expected 11", {Button_0, Button_0_Press});
        end
        Button_0_Raw = 1'b1;
        step(LAT);
        checks++;
        if ({Button_0, Button_0_Press} !== 2'b11) begin
            failures++;
            $display("FAIL release_early: got %b expected 11", {Button_0, Button_0_Press});
        end
        step(1);
        checks++;
        if ({Button_0, Button_0_Press} !== 2'b01) begin
            failures++;
            $display("FAIL release_fall: got %b expected 01", {Button_0, Button_0_Press});
        end
    endtask

    task automatic test_clear();
        PressClr = 2'b01;
        step(1);
        PressClr = 2'b00;
        checks++;
        if (Button_0_Press !== 1'b0) begin
            failures++;
            $display("FAIL clear: got %b expected 0", Button_0_Press);
        end
    endtask

    task automatic test_set_clear_same_edge();
        Button_0_Raw = 1'b0;
        step(LAT + 1);
        Button_0_Raw = 1'b1;
        step(LAT + 1);
        checks++;
        if ({Button_0, Button_0_Press} !== 2'b01) begin
            failures++;
            $display("FAIL flag_after_release: got %b expected 01", {Button_0, Button_0_Press});
        end
        Button_0_Raw = 1'b0;
        step(LAT);
        PressClr = 2'b01;
        step(1);
        PressClr = 2'b00;
        checks++;
        if ({Button_0, Button_0_Press} !== 2'b11) begin
            failures++;
            $display("FAIL set_wins: got %b expected 11", {Button_0, Button_0_Press});
        end
        PressClr = 2'b01;
        step(1);
        PressClr = 2'b00;
        checks++;
        if ({Button_0, Button_0_Press} !== 2'b10) begin
            failures++;
            $display("FAIL clear_alone: got %b expected 10", {Button_0, Button_0_Press});
        end
        Button_0_Raw = 1'b1;
        step(LAT + 1);
    endtask

    task automatic test_button1();
        Button_1_Raw = 1'b0;
        step(LAT + 1);
        checks++;
        if ({Button_1, Button_1_Press, Button_0_Press} !== 3'b110) begin
            failures++;
            $display("FAIL button1_press: got %b expected 110", {Button_1, Button_1_Press, Button_0_Press});
        end
        PressClr = 2'b10;
        Button_1_Raw = 1'b1;
        step(1);
        PressClr = 2'b00;
        step(LAT);
        checks++;
        if ({Button_1, Button_1_Press} !== 2'b00) begin
            failures++;
            $display("FAIL button1_clear: got %b expected 00", {Button_1, Button_1_Press});
        end
    endtask

    task automatic test_switch_glitch();
`ifdef RVC_FPGA_IN_DEBOUNCE_EN
        Switch_Raw = 10'h008;
        step(3);
        Switch_Raw = 10'h000;
        for (int c = 0; c < 12; c++) begin
            step(1);
            checks++;
            if ({Switch, SwitchChange} !== 11'h000) begin
                failures++;
                $display("FAIL glitch cycle %0d: got %h expected 000", c, {Switch, SwitchChange});
            end
        end
`endif
        Switch_Raw = 10'h008;
        step(LAT);
        checks++;
        if ({Switch, SwitchChange} !== 11'h000) begin
            failures++;
            $display("FAIL sw3_early: got %h expected 000", {Switch, SwitchChange});
        end
        step(1);
        checks++;
        if ({Switch, SwitchChange} !== 11'h011) begin
            failures++;
            $display("FAIL sw3_update: got %h expected 011", {Switch, SwitchChange});
        end
        step(1);
        checks++;
        if ({Switch, SwitchChange} !== 11'h010) begin
            failures++;
            $display("FAIL sw3_pulse_end: got %h expected 010", {Switch, SwitchChange});
        end
        Switch_Raw = 10'h000;
        step(LAT + 2);
    endtask

    task automatic test_switch_all();
        Switch_Raw = 10'h3FF;
        step(LAT);
        checks++;
        if ({Switch, SwitchChange} !== 11'h000) begin
            failures++;
            $display("FAIL all_early: got %h expected 000", {Switch, SwitchChange});
        end
        step(1);
        checks++;
        if ({Switch, SwitchChange} !== 11'h7FF) begin
            failures++;
            $display("FAIL all_update: got %h expected 7FF", {Switch, SwitchChange});
        end
        step(1);
        checks++;
        if ({Switch, SwitchChange} !== 11'h7FE) begin
            failures++;
            $display("FAIL all_pulse_end: got %h expected 7FE", {Switch, SwitchChange});
        end
        Switch_Raw = 10'h000;
        step(LAT + 2);
    endtask

    task automatic test_reset_midcount();
        Button_1_Raw = 1'b0;
        step(PRE);
        Rst = 1'b0;
        step(2);
        checks++;
        if ({Button_1, Button_1_Press} !== 2'b00) begin
            failures++;
            $display("FAIL midcount_in_reset: got %b expected 00", {Button_1, Button_1_Press});
        end
        Rst = 1'b1;
        step(LAT);
        checks++;
        if ({Button_1, Button_1_Press} !== 2'b00) begin
            failures++;
            $display("FAIL midcount_early: got %b expected 00", {Button_1, Button_1_Press});
        end
        step(1);
        checks++;
        if ({Button_1, Button_1_Press} !== 2'b11) begin
            failures++;
            $display("FAIL midcount_update: got %b expected 11", {Button_1, Button_1_Press});
        end
    endtask

    initial begin
        test_reset();
        test_press_latency();
        test_clear();
        test_set_clear_same_edge();
        test_button1();
        test_switch_glitch();
        test_switch_all();
        test_reset_midcount();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
